sd_spi_host: RTL and testbench

SPI-mode SD host engine for the BRIDGE design. It drives MOSI and samples MISO toward the SD card, and executes one single-block transfer per request: a CMD17 read or a CMD24 write of one 64-bit block. The upstream bridge logic hands it an operation, a 16-bit block address and write data. The engine returns the read data and a status pulse once the card transaction is finished.

---
 rtl/sd_spi_pkg.sv | 37 +++
 rtl/sd_crc_serial.sv | 54 +++++
 rtl/sd_spi_host.sv | 263 ++++++++++++++++++++++++++
 tb/tb_sd_spi_host.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_spi_pkg
// Description : Shared types and constants for the SPI-mode SD host engine:
//               FSM state encoding, command indices, CRC polynomials and the
//               data-token / data-response byte values.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_spi_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_CMD      = 4'd1,
    ST_WAIT_R1  = 4'd2,
    ST_R1       = 4'd3,
    ST_RD_TOKEN = 4'd4,
    ST_RD_DATA  = 4'd5,
    ST_RD_CRC   = 4'd6,
    ST_WR_GAP   = 4'd7,
    ST_WR_TOKEN = 4'd8,
    ST_WR_DATA  = 4'd9,
    ST_WR_CRC   = 4'd10,
    ST_WAIT_DR  = 4'd11,
    ST_DR       = 4'd12,
    ST_BUSY     = 4'd13,
    ST_DONE     = 4'd14
  } state_e;

  localparam logic [5:0]  CMD_READ   = 6'd17;
  localparam logic [5:0]  CMD_WRITE  = 6'd24;
  localparam logic [6:0]  CRC7_POLY  = 7'h09;
  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [7:0]  TOKEN      = 8'hFE;
  localparam logic [7:0]  DRESP_OK   = 8'h05;

endpackage
`default_nettype wire

// File: rtl/sd_crc_serial.sv
`default_nettype none
// ============================================================================
// Module      : sd_crc_serial
// Description : Bit-serial CRC generator, MSB-first, zero initial value.
//               clr_i zeroes the register; when clr_i and en_i are both high
//               the incoming bit is folded into a freshly cleared CRC, so the
//               first bit of a field can be absorbed on the same edge that
//               starts the field.
// Ports       : clk, rst    - clock, async active-high reset
//               clr_i       - clear CRC to zero
//               en_i, bit_i - absorb bit_i this cycle
//               crc_o       - current CRC value
// Revision    : 1.0 - initial release
// ============================================================================
module sd_crc_serial
  import sd_spi_pkg::*;
#(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] POLY  = CRC7_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] crc_o
);

  logic [WIDTH-1:0] crc_q;
  logic [WIDTH-1:0] crc_d;
  logic [WIDTH-1:0] base;
  logic             fb;

  always_comb begin
    base  = clr_i ? '0 : crc_q;
    fb    = bit_i ^ base[WIDTH-1];
    crc_d = base;
    if (en_i) begin
      crc_d = {base[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/sd_spi_host.sv
`default_nettype none
// ============================================================================
// Module      : sd_spi_host
// Description : SPI-mode SD host engine. Executes one single-block CMD17 read
//               or CMD24 write of a 64-bit block per accepted request and
//               returns read data plus a status pulse.
// Ports       : clk, rst                  - clock, async active-high reset
//               req_valid/req_ready       - request handshake
//               req_write/addr/wdata      - operation, block address, data
//               rsp_valid/rsp_rdata/err   - completion pulse, data, status
//               MOSI / MISO               - serial lines to/from the card
// Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_host
  import sd_spi_pkg::*;
#(
  parameter int UNIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        MOSI,
  input  logic        MISO
);

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;       // bits already handled in current field
  logic [63:0] sr_q, sr_d;         // shared shift register for every field
  logic [63:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        mosi_q, mosi_d;
  logic        err_q, err_d;
  logic [63:0] rdata_q, rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        crc7_en, crc7_bit, crc16_clr, crc16_en, crc16_bit;
  logic [6:0]  crc7_val;
  logic [15:0] crc16_val;
  logic [39:0] cmd_word;
  logic [6:0]  cnt_inc;
  logic        mism;

  // First 40 bits of the command frame: start, transmission, index, argument.
  assign cmd_word = {2'b01, (req_write ? CMD_WRITE : CMD_READ), 16'h0000, req_addr};
  assign cnt_inc  = cnt_q + 7'd1;

  sd_crc_serial #(.WIDTH(7), .POLY(CRC7_POLY)) u_crc7 (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == ST_IDLE),
    .en_i  (crc7_en),
    .bit_i (crc7_bit),
    .crc_o (crc7_val)
  );

  assign crc16_clr = (state_q == ST_RD_TOKEN) || (state_q == ST_WR_TOKEN);

  sd_crc_serial #(.WIDTH(16), .POLY(CRC16_POLY)) u_crc16 (
    .clk   (clk),
    .rst   (rst),
    .clr_i (crc16_clr),
    .en_i  (crc16_en),
    .bit_i (crc16_bit),
    .crc_o (crc16_val)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    mosi_d    = 1'b1;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rsp_err_d = rsp_err_q;
    crc7_en   = 1'b0;
    crc7_bit  = 1'b0;
    crc16_en  = 1'b0;
    crc16_bit = 1'b0;
    mism      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          // Start bit leaves on the acceptance edge and enters the CRC7.
          mosi_d   = cmd_word[39];
          crc7_en  = 1'b1;
          crc7_bit = cmd_word[39];
          sr_d     = {cmd_word[38:0], 25'd0};
          cnt_d    = 7'd1;
          write_d  = req_write;
          wdata_d  = req_wdata;
          err_d    = 1'b0;
          state_d  = ST_CMD;
        end
      end
      ST_CMD: begin
        if (cnt_q < 7'd40) begin
          mosi_d   = sr_q[63];
          crc7_en  = 1'b1;
          crc7_bit = sr_q[63];
          sr_d     = {sr_q[62:0], 1'b0};
        end else if (cnt_q == 7'd40) begin
          // CRC7 is final now; send its MSB and queue the rest plus end bit.
          mosi_d = crc7_val[6];
          sr_d   = {crc7_val[5:0], 1'b1, 57'd0};
        end else begin
          mosi_d = sr_q[63];
          sr_d   = {sr_q[62:0], 1'b0};
        end
        cnt_d = cnt_inc;
        if (cnt_q == 7'd47) begin
          cnt_d   = 7'd0;
          state_d = ST_WAIT_R1;
        end
      end
      ST_WAIT_R1: begin
        if (!MISO) begin
          cnt_d   = 7'd1;
          state_d = ST_R1;
        end
      end
      ST_R1: begin
        cnt_d = cnt_inc;
        if (cnt_q == 7'd7) begin
          cnt_d   = 7'd0;
          state_d = write_q ? ST_WR_GAP : ST_RD_TOKEN;
        end
      end
      ST_RD_TOKEN: begin
        if (!MISO) begin
          cnt_d   = 7'd0;
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        sr_d      = {sr_q[62:0], MISO};
        crc16_en  = 1'b1;
        crc16_bit = MISO;
        cnt_d     = cnt_inc;
        if (cnt_q == 7'd63) begin
          cnt_d   = 7'd0;
          state_d = ST_RD_CRC;
        end
      end
      ST_RD_CRC: begin
        // Received CRC is checked bit by bit so sr_q can keep the data.
        mism  = MISO ^ crc16_val[4'd15 - cnt_q[3:0]];
        err_d = err_q | mism;
        cnt_d = cnt_inc;
        if (cnt_q == 7'd15) begin
          rdata_d   = sr_q;
          rsp_err_d = err_q | mism;
          state_d   = ST_DONE;
        end
      end
      ST_WR_GAP: begin
        cnt_d = cnt_inc;
        if (cnt_q == 7'(UNIT - 1)) begin
          mosi_d  = TOKEN[7];
          sr_d    = {TOKEN[6:0], 57'd0};
          cnt_d   = 7'd1;
          state_d = ST_WR_TOKEN;
        end
      end
      ST_WR_TOKEN: begin
        mosi_d = sr_q[63];
        sr_d   = {sr_q[62:0], 1'b0};
        cnt_d  = cnt_inc;
        if (cnt_q == 7'd7) begin
          sr_d    = wdata_q;
          cnt_d   = 7'd0;
          state_d = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        mosi_d    = sr_q[63];
        crc16_en  = 1'b1;
        crc16_bit = sr_q[63];
        sr_d      = {sr_q[62:0], 1'b0};
        cnt_d     = cnt_inc;
        if (cnt_q == 7'd63) begin
          cnt_d   = 7'd0;
          state_d = ST_WR_CRC;
        end
      end
      ST_WR_CRC: begin
        mosi_d = crc16_val[4'd15 - cnt_q[3:0]];
        cnt_d  = cnt_inc;
        if (cnt_q == 7'd15) begin
          cnt_d   = 7'd0;
          state_d = ST_WAIT_DR;
        end
      end
      ST_WAIT_DR: begin
        if (!MISO) begin
          sr_d    = {sr_q[62:0], MISO};
          cnt_d   = 7'd1;
          state_d = ST_DR;
        end
      end
      ST_DR: begin
        sr_d  = {sr_q[62:0], MISO};
        cnt_d = cnt_inc;
        if (cnt_q == 7'd7) begin
          err_d   = ({sr_q[6:0], MISO} != DRESP_OK);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (MISO) begin
          rsp_err_d = err_q;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      mosi_q    <= 1'b1;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      mosi_q    <= mosi_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign MOSI      = mosi_q;
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sd_spi_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_spi_host
// Description : Self-checking bench for sd_spi_host with a behavioural SD card
//               and a scoreboard of expected command frames and responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_spi_host;

  localparam int UNIT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [63:0] req_wdata = 64'h0;
  logic        MISO = 1'b1;
  logic        req_ready, rsp_valid, rsp_err, MOSI;
  logic [63:0] rsp_rdata;

  always #5 clk = ~clk;

  sd_spi_host #(.UNIT(UNIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          rsp_seen = 0;
  int          n_done = 0;
  int          rdy_viol = 0;
  logic        in_txn = 1'b0;
  logic [63:0] last_rd = 64'h0;
  logic [7:0]  tok_v = 8'hFE;
  logic [47:0] frame_q [$];
  exp_t        rsp_q [$];
  logic [63:0] mem [logic [15:0]];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rsp_valid === 1'b1) rsp_seen++;
    if (in_txn && req_ready !== 1'b0) rdy_viol++;
  endtask

  task automatic send_bit(input logic b);
    MISO = b;
    tick();
  endtask

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'h0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16(input logic [63:0] d);
    logic [15:0] c;
    logic        fb;
    c = 16'h0;
    for (int i = 63; i >= 0; i--) begin
      fb = d[i] ^ c[15];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  function automatic logic [47:0] make_frame(input logic [5:0] cmd, input logic [15:0] a);
    logic [39:0] h;
    h = {2'b01, cmd, 16'h0000, a};
    return {h, crc7(h), 1'b1};
  endfunction

  function automatic logic [63:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return {a, ~a, a ^ 16'hC3C3, 16'h5AA5};
  endfunction

  // Present a request, wait for acceptance, then capture the 48-bit frame.
  task automatic issue(input logic wr, input logic [15:0] a, input logic [63:0] d,
                       output logic [47:0] f);
    logic rdy;
    int   tries;
    tries = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    do begin
      rdy = req_ready;
      tick();
      tries++;
    end while (!rdy && tries < 20);
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = 16'h0;
    req_wdata = 64'h0;
    in_txn    = 1'b1;
    chk("accept_ready", 64'(rdy), 64'(1));
    chk("ready_low_after_accept", 64'(req_ready), 64'(0));
    f[47] = MOSI;
    for (int i = 46; i >= 0; i--) begin
      tick();
      f[i] = MOSI;
    end
  endtask

  task automatic check_frame(input logic [47:0] f);
    chk("frame_q_size", 64'(frame_q.size()), 64'(1));
    if (frame_q.size() != 0) chk("cmd_frame", 64'(f), 64'(frame_q.pop_front()));
  endtask

  task automatic card_r1(input int d1);
    repeat (d1) send_bit(1'b1);
    repeat (8) send_bit(1'b0);
  endtask

  task automatic check_rsp();
    exp_t e;
    chk("rsp_q_size", 64'(rsp_q.size()), 64'(1));
    chk("rsp_valid", 64'(rsp_valid), 64'(1));
    if (rsp_q.size() != 0) begin
      e = rsp_q.pop_front();
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_err", 64'(rsp_err), 64'(e.err));
    end
    n_done++;
    MISO   = 1'b1;
    in_txn = 1'b0;
    tick();
    chk("rsp_valid_pulse", 64'(rsp_valid), 64'(0));
    chk("ready_after_done", 64'(req_ready), 64'(1));
    chk("ready_low_in_txn", 64'(rdy_viol), 64'(0));
  endtask

  task automatic do_read(input logic [15:0] a, input int d1, input int d2, input logic bad);
    exp_t        e;
    logic [47:0] f;
    logic [63:0] row;
    logic [15:0] c;
    row = mem_rd(a);
    frame_q.push_back(make_frame(6'd17, a));
    e.rdata = row;
    e.err   = bad;
    rsp_q.push_back(e);
    last_rd = row;
    issue(1'b0, a, 64'h0, f);
    check_frame(f);
    card_r1(d1);
    repeat (d2) send_bit(1'b1);
    for (int i = 7; i >= 0; i--) send_bit(tok_v[i]);
    for (int i = 63; i >= 0; i--) send_bit(row[i]);
    c = crc16(row) ^ {15'd0, bad};
    for (int i = 15; i >= 0; i--) send_bit(c[i]);
    check_rsp();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [63:0] data, input int d1,
                          input int d2, input logic [7:0] dr, input int busy);
    exp_t        e;
    logic [47:0] f;
    logic [63:0] got;
    logic [15:0] gc;
    int          hi;
    frame_q.push_back(make_frame(6'd24, a));
    e.rdata = last_rd;
    e.err   = (dr != 8'h05);
    rsp_q.push_back(e);
    issue(1'b1, a, data, f);
    check_frame(f);
    card_r1(d1);
    hi = 0;
    while (MOSI === 1'b1 && hi < 200) begin
      hi++;
      tick();
    end
    chk("pre_token_high", 64'(hi), 64'(UNIT + 7));
    for (int i = 63; i >= 0; i--) begin
      tick();
      got[i] = MOSI;
    end
    for (int i = 15; i >= 0; i--) begin
      tick();
      gc[i] = MOSI;
    end
    chk("wr_data", got, data);
    chk("wr_crc16", 64'(gc), 64'(crc16(data)));
    if (dr == 8'h05) mem[a] = data;
    repeat (d2) send_bit(1'b1);
    for (int i = 7; i >= 0; i--) send_bit(dr[i]);
    repeat (busy) send_bit(1'b0);
    chk("no_early_valid", 64'(rsp_valid), 64'(0));
    send_bit(1'b1);
    check_rsp();
  endtask

  initial begin
    logic [47:0] f;
    logic [15:0] ra;
    int          hi;

    rst = 1'b1;
    repeat (3) tick();
    chk("reset_mosi", 64'(MOSI), 64'(1));
    chk("reset_ready", 64'(req_ready), 64'(1));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rdata", rsp_rdata, 64'h0);
    chk("reset_err", 64'(rsp_err), 64'(0));
    rst = 1'b0;
    tick();
    chk("idle_mosi", 64'(MOSI), 64'(1));

    mem[16'h0005] = 64'h0123_4567_89AB_CDEF;
    do_read(16'h0005, 2 * UNIT, 3, 1'b0);
    do_write(16'hFFFF, 64'hDEAD_BEEF_CAFE_F00D, 4, 2, 8'h05, 5 * UNIT);
    do_read(16'hFFFF, 0, 0, 1'b0);
    do_read(16'h0005, 5, 1, 1'b1);
    do_write(16'h0123, 64'h1111_2222_3333_4444, 1, 0, 8'h0B, 0);

    // Reset in the middle of the write data field.
    frame_q.push_back(make_frame(6'd24, 16'h00AA));
    issue(1'b1, 16'h00AA, 64'hA5A5_5A5A_0F0F_F0F0, f);
    check_frame(f);
    card_r1(3);
    hi = 0;
    while (MOSI === 1'b1 && hi < 200) begin
      hi++;
      tick();
    end
    chk("rst_pre_token_high", 64'(hi), 64'(UNIT + 7));
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("midrst_mosi", 64'(MOSI), 64'(1));
    chk("midrst_ready", 64'(req_ready), 64'(1));
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    in_txn  = 1'b0;
    last_rd = 64'h0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("postrst_ready", 64'(req_ready), 64'(1));
    chk("postrst_rdata", rsp_rdata, 64'h0);
    do_read(16'h0005, 1, 1, 1'b0);

    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 2))
        0:       ra = 16'h0005;
        1:       ra = 16'hFFFF;
        default: ra = 16'($urandom_range(0, 65535));
      endcase
      if ($urandom_range(0, 1) == 1)
        do_write(ra, {$urandom, $urandom}, int'($urandom_range(0, 12)),
                 int'($urandom_range(0, 12)),
                 ($urandom_range(0, 3) == 0) ? 8'h0B : 8'h05,
                 int'($urandom_range(0, 2)) * UNIT);
      else
        do_read(ra, int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                $urandom_range(0, 4) == 0);
    end

    chk("rsp_total", 64'(rsp_seen), 64'(n_done));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
